id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Pipeline stage directly downstream of the register file. Captures the two register-file read values plus decode fields into the ID/EX boundary register that feeds the ALU.
- Forces $0 reads to zero and bypasses the writeback result when it targets a source register.
- Detects load-use hazards and inserts a one-cycle bubble with backpressure to decode.
- Supports stall (hold) and flush (kill), and keeps a saturating bubble counter for watermark/performance readout.

Parameters:
- CTRL_W, 8, width of the decoded control bundle passed to execute.
- LOAD_BIT, 0, index in ctrl of the memory-read (load) flag.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode presents a valid instruction.
- id_ready  out  1  stage accepts the decode instruction this cycle.
- rs_addr  in  5  source register 1 address (drives register-file addr1).
- rt_addr  in  5  source register 2 address (drives register-file addr2).
- rt_used  in  1  instruction reads rt (0 for immediate forms).
- rd_addr  in  5  destination register.
- rf_out1  in  32  register-file read value for rs.
- rf_out2  in  32  register-file read value for rt.
- imm  in  32  sign/zero-extended immediate from decode.
- ctrl  in  CTRL_W  decoded control bundle.
- wb_we  in  1  writeback write enable (same signal as register-file rw).
- wb_addr  in  5  writeback destination (register-file addr3).
- wb_data  in  32  writeback data (register-file data3).
- stall  in  1  downstream hold request.
- flush  in  1  kill the instruction in this stage (branch taken).
- ex_valid  out  1  ex_* outputs hold a live instruction.
- ex_a  out  32  operand A.
- ex_b  out  32  operand B.
- ex_imm  out  32  registered immediate.
- ex_rd  out  5  registered destination.
- ex_ctrl  out  CTRL_W  registered control bundle.
- bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles.

Behaviour:
- Reset (rst_n=0, asynchronous): ex_valid=0, ex_a=ex_b=ex_imm=0, ex_rd=0, ex_ctrl=0, bubble_cnt=0, FSM=RUN. id_ready reads 0 while in reset.
- Operand select, combinational, evaluated per source:
  - If the address is 0, the operand is 0 regardless of rf_out or bypass.
  - Else if wb_we=1 and wb_addr equals the address, the operand is wb_data.
  - Else the operand is rf_out1 (rs) or rf_out2 (rt).
- Load-use hazard condition: hazard = id_valid & ex_valid & ex_ctrl[LOAD_BIT] & (ex_rd!=0) & ((ex_rd==rs_addr) | (rt_used & ex_rd==rt_addr)).
- FSM states: RUN, BUBBLE.
- Per-posedge priority, highest first:
  1. flush=1: ex_valid<=0, ex_ctrl<=0, FSM<=RUN. Other ex_* fields are don't-care but keep their previous values.
  2. stall=1: all ex_* outputs and FSM hold; id_ready=0.
  3. RUN with hazard=1: ex_valid<=0, ex_ctrl<=0 (bubble), FSM<=BUBBLE, bubble_cnt<=bubble_cnt+1, saturating at all-ones. id_ready=0, so decode holds its instruction.
  4. BUBBLE: unconditionally return to RUN. The load has now left EX and the held instruction is evaluated as in RUN on this edge; the bubble lasts exactly one cycle.
  5. RUN, no hazard: if id_valid=1, latch the selected operands (ex_a from rs, ex_b from rt), imm, rd_addr and ctrl, and set ex_valid<=1. If id_valid=0, ex_valid<=0 and ex_ctrl<=0.
- id_ready, combinational: ~stall & ~(FSM==RUN & hazard) & rst_n. flush does not deassert id_ready; the incoming decode instruction is also discarded on flush.
- Latency: one cycle from decode acceptance to ex_valid, two cycles when a bubble is inserted.
- Simultaneous flush and hazard: flush wins; no bubble is counted.
- Simultaneous stall and hazard: stall wins; no bubble is counted, and the hazard is re-evaluated after the stall releases.
- A bypass match is evaluated at the capture edge only; stalled operands are not refreshed.
- Reset asserted mid-bubble returns the FSM to RUN with all outputs zeroed.

Test Plan:
- Reset, then id_valid=1, rs=9, rt=10, rf_out1=0x10, rf_out2=0x8, no wb -> next cycle ex_valid=1, ex_a=0x10, ex_b=0x8.
- rs=0, rf_out1=0xDEADBEEF, wb_we=1, wb_addr=0, wb_data=5 -> ex_a=0.
- rs=12, rf_out1=0, wb_we=1, wb_addr=12, wb_data=0x1234 -> ex_a=0x1234.
- Load into rd=8 in EX, next instruction rs=8 -> id_ready=0 for one cycle, ex_valid=0 for one cycle, bubble_cnt=1; the following cycle ex_valid=1 with operand from wb bypass when wb_addr=8.
- Same load-use setup with flush=1 on the hazard cycle -> ex_valid=0, bubble_cnt unchanged, FSM in RUN; with stall=1 instead -> outputs hold and bubble_cnt unchanged.
- Force bubble_cnt to 0xFFFF, trigger a hazard -> bubble_cnt stays 0xFFFF; assert rst_n=0 asynchronously mid-BUBBLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand capture with bypass, load-use bubble, stall/flush
module id_ex_operand_stage #(
  parameter int CTRL_W   = 8,
  parameter int LOAD_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic              rt_used,
  input  logic [4:0]        rd_addr,
  input  logic [31:0]       rf_out1,
  input  logic [31:0]       rf_out2,
  input  logic [31:0]       imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t      state, state_d;
  logic        hazard;
  logic [31:0] op_a, op_b;
  logic        load_en, clear_en, bubble_en;

  // Operand select: $0 reads as zero, then writeback bypass, then register file
  always_comb begin
    op_a = rf_out1;
    op_b = rf_out2;
    if (rs_addr == 5'd0)
      op_a = 32'd0;
    else if (wb_we && (wb_addr == rs_addr))
      op_a = wb_data;
    if (rt_addr == 5'd0)
      op_b = 32'd0;
    else if (wb_we && (wb_addr == rt_addr))
      op_b = wb_data;
  end

  // Load in EX whose destination feeds the instruction waiting in decode
  always_comb begin
    hazard = id_valid & ex_valid & ex_ctrl[LOAD_BIT] & (ex_rd != 5'd0) &
             ((ex_rd == rs_addr) | (rt_used & (ex_rd == rt_addr)));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_d;
  end

  // Next state and per-edge actions, flush > stall > bubble > capture
  always_comb begin
    state_d   = state;
    load_en   = 1'b0;
    clear_en  = 1'b0;
    bubble_en = 1'b0;
    id_ready  = ~stall & ~((state == RUN) & hazard) & rst_n;
    if (flush) begin
      clear_en = 1'b1;
      state_d  = RUN;
    end else if (stall) begin
      state_d = state;
    end else if ((state == RUN) && hazard) begin
      clear_en  = 1'b1;
      bubble_en = 1'b1;
      state_d   = BUBBLE;
    end else begin
      // Leaving BUBBLE the held instruction is evaluated like a normal RUN cycle
      state_d = RUN;
      if (id_valid)
        load_en = 1'b1;
      else
        clear_en = 1'b1;
    end
  end

  // ID/EX boundary register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_a     <= 32'd0;
      ex_b     <= 32'd0;
      ex_imm   <= 32'd0;
      ex_rd    <= 5'd0;
      ex_ctrl  <= '0;
    end else if (load_en) begin
      ex_valid <= 1'b1;
      ex_a     <= op_a;
      ex_b     <= op_b;
      ex_imm   <= imm;
      ex_rd    <= rd_addr;
      ex_ctrl  <= ctrl;
    end else if (clear_en) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end
  end

  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (bubble_en && (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic              id_ready;
  logic [4:0]        rs_addr, rt_addr, rd_addr;
  logic              rt_used;
  logic [31:0]       rf_out1, rf_out2, imm;
  logic [CTRL_W-1:0] ctrl;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic              stall, flush;
  logic              ex_valid;
  logic [31:0]       ex_a, ex_b, ex_imm;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int tests = 0;
  int fails = 0;

  id_ex_operand_stage #(.CTRL_W(CTRL_W), .LOAD_BIT(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rt_used(rt_used), .rd_addr(rd_addr),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .imm(imm), .ctrl(ctrl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] rs, input logic [31:0] v1,
                         input logic [4:0] rt, input logic [31:0] v2, input logic use_rt,
                         input logic [4:0] rd, input logic [CTRL_W-1:0] c);
    id_valid = 1'b1;
    rs_addr  = rs;
    rf_out1  = v1;
    rt_addr  = rt;
    rf_out2  = v2;
    rt_used  = use_rt;
    rd_addr  = rd;
    ctrl     = c;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; rs_addr = 0; rt_addr = 0; rt_used = 1'b0; rd_addr = 0;
    rf_out1 = 0; rf_out2 = 0; imm = 0; ctrl = 0; wb_we = 1'b0; wb_addr = 0; wb_data = 0;
    stall = 1'b0; flush = 1'b0;
    #1;
    check("rst_id_ready", id_ready, 0);
    step(); step();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_a", ex_a, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("run_id_ready", id_ready, 1);

    // Plain capture
    present(5'd9, 32'h10, 5'd10, 32'h8, 1'b1, 5'd3, 8'h02);
    imm = 32'h55;
    step();
    check("cap_valid", ex_valid, 1);
    check("cap_a", ex_a, 32'h10);
    check("cap_b", ex_b, 32'h8);
    check("cap_imm", ex_imm, 32'h55);
    check("cap_rd", ex_rd, 3);
    check("cap_ctrl", ex_ctrl, 8'h02);

    // $0 ignores both rf and bypass
    present(5'd0, 32'hDEADBEEF, 5'd10, 32'h7, 1'b1, 5'd3, 8'h02);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
    step();
    check("zero_a", ex_a, 0);
    check("zero_b_rf", ex_b, 32'h7);

    // Writeback bypass on rs, not on rt
    present(5'd12, 32'h0, 5'd13, 32'h99, 1'b1, 5'd3, 8'h02);
    wb_addr = 5'd12; wb_data = 32'h1234;
    step();
    check("byp_a", ex_a, 32'h1234);
    check("byp_b_rf", ex_b, 32'h99);
    wb_we = 1'b0;

    // Load-use bubble then bypassed operand
    present(5'd1, 32'h100, 5'd2, 32'h20, 1'b1, 5'd8, 8'h01);
    step();
    check("ld_valid", ex_valid, 1);
    check("ld_ctrl", ex_ctrl, 8'h01);
    present(5'd8, 32'hBAD, 5'd2, 32'h20, 1'b1, 5'd4, 8'h02);
    #1;
    check("lu_id_ready", id_ready, 0);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", ex_ctrl, 0);
    check("lu_bubble_cnt", bubble_cnt, 1);
    check("lu_bubble_ready", id_ready, 1);
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFE;
    step();
    check("lu_after_valid", ex_valid, 1);
    check("lu_after_a", ex_a, 32'hCAFE);
    check("lu_after_b", ex_b, 32'h20);
    check("lu_after_rd", ex_rd, 4);
    check("lu_after_cnt", bubble_cnt, 1);
    wb_we = 1'b0;

    // Flush on the hazard cycle wins
    present(5'd1, 32'h100, 5'd2, 32'h20, 1'b1, 5'd8, 8'h01);
    step();
    present(5'd8, 32'hBAD, 5'd2, 32'h20, 1'b1, 5'd4, 8'h02);
    flush = 1'b1;
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_ctrl", ex_ctrl, 0);
    check("fl_cnt", bubble_cnt, 1);
    flush = 1'b0;
    #1;
    check("fl_run_ready", id_ready, 1);
    step();
    check("fl_next_valid", ex_valid, 1);
    check("fl_next_a", ex_a, 32'hBAD);

    // Immediate form: rt match does not hazard; then stall beats hazard
    present(5'd1, 32'h100, 5'd2, 32'h20, 1'b1, 5'd8, 8'h01);
    step();
    present(5'd1, 32'h1, 5'd8, 32'h2, 1'b0, 5'd4, 8'h02);
    #1;
    check("imm_no_hazard", id_ready, 1);
    present(5'd8, 32'hBAD, 5'd2, 32'h20, 1'b1, 5'd4, 8'h02);
    stall = 1'b1;
    #1;
    check("st_id_ready", id_ready, 0);
    step(); step();
    check("st_hold_valid", ex_valid, 1);
    check("st_hold_ctrl", ex_ctrl, 8'h01);
    check("st_hold_rd", ex_rd, 8);
    check("st_hold_a", ex_a, 32'h100);
    check("st_cnt", bubble_cnt, 1);
    stall = 1'b0;
    #1;
    check("st_rel_hazard", id_ready, 0);
    step();
    check("st_rel_bubble", ex_valid, 0);
    check("st_rel_cnt", bubble_cnt, 2);
    step();
    check("st_rel_cap_a", ex_a, 32'hBAD);

    // Self-dependent load: bubble every other cycle, counter saturates
    present(5'd8, 32'h77, 5'd0, 32'h0, 1'b0, 5'd8, 8'h01);
    step();
    for (int i = 0; i < 31; i++) step();
    check("sat_in_bubble", ex_valid, 0);
    check("sat_cnt", bubble_cnt, 4'hF);
    check("sat_ex_a", ex_a, 32'h77);

    // Asynchronous reset mid-bubble
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", ex_valid, 0);
    check("arst_a", ex_a, 0);
    check("arst_rd", ex_rd, 0);
    check("arst_cnt", bubble_cnt, 0);
    check("arst_ready", id_ready, 0);
    step();
    rst_n = 1'b1;
    present(5'd9, 32'h31, 5'd0, 32'h0, 1'b0, 5'd5, 8'h02);
    step();
    check("post_rst_cap", ex_a, 32'h31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
